// File: rtl/trd_cmd_seq_pkg.sv
// Shared types for the thread-command sequencer: command/response codes,
// the queued command record and the sequencer FSM states.
package trd_cmd_seq_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_INIT = 3'd1,
    CMD_KILL = 3'd2,
    CMD_SLP  = 3'd3,
    CMD_WAKE = 3'd4
  } trd_cmd_e;

  typedef enum logic [1:0] {
    RSP_OK  = 2'd0,
    RSP_OF  = 2'd1,
    RSP_INV = 2'd2
  } trd_rsp_e;

  typedef struct packed {
    trd_cmd_e    op;
    logic [2:0]  act;
    logic [2:0]  obj;
    logic [31:0] pc;
  } trd_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } seq_state_e;

  // Only INIT..WAKE are worth queueing; NOP and codes 5-7 are dropped at the door.
  function automatic logic is_cmd(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

endpackage

// File: rtl/trd_cmd_seq_if.sv
// Request/response bus between the execute stage and the sequencer.
interface trd_cmd_seq_if;
  import trd_cmd_seq_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [2:0]  req_act_trd;
  logic [2:0]  req_obj_trd;
  logic [31:0] req_pc;
  logic        rsp_valid;
  trd_rsp_e    rsp_status;
  logic [2:0]  rsp_trd;

  modport master (
    output req_valid, req_op, req_act_trd, req_obj_trd, req_pc,
    input  req_ready, rsp_valid, rsp_status, rsp_trd
  );

  modport slave (
    input  req_valid, req_op, req_act_trd, req_obj_trd, req_pc,
    output req_ready, rsp_valid, rsp_status, rsp_trd
  );
endinterface

// File: rtl/trd_cmd_fifo.sv
// Synchronous FIFO of thread commands; DEPTH must be a power of two so the
// pointers wrap naturally.
module trd_cmd_fifo
  import trd_cmd_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  trd_cmd_t                 data_i,
  input  logic                     pop_i,
  output trd_cmd_t                 data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);

  trd_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/trd_cmd_seq.sv
// Thread-command sequencer: queues requests, pre-checks them against
// thread_ctrl status, issues one command pulse at a time and reports the outcome.
module trd_cmd_seq
  import trd_cmd_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  trd_cmd_seq_if.slave        bus,
  input  logic                flush,
  input  logic                stall,
  input  logic [7:0]          valid_trd,
  input  logic                trd_full,
  input  logic                trd_of,
  input  logic                invalid_op,
  input  logic [2:0]          new_trd,
  output logic                init_trd,
  output logic                kill,
  output logic                slp,
  output logic                wake,
  output logic [2:0]          act_trd,
  output logic [2:0]          obj_trd,
  output logic [31:0]         init_pc,
  output logic                busy
);
  seq_state_e            state_q;
  trd_cmd_t              cmd_q, head, push_data;
  trd_rsp_e              rsp_status_q, chk_status;
  logic [2:0]            rsp_trd_q;
  logic                  full, empty, push, pop, fire;
  logic [$clog2(DEPTH):0] count;

  assign push_data = '{op: trd_cmd_e'(bus.req_op), act: bus.req_act_trd,
                       obj: bus.req_obj_trd, pc: bus.req_pc};
  assign push = bus.req_valid && !full && is_cmd(bus.req_op);
  assign pop  = (state_q == S_IDLE) && !empty && !flush;

  trd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  always_comb begin
    chk_status = RSP_OK;
    if (cmd_q.op == CMD_INIT && trd_full)                chk_status = RSP_OF;
    else if (!valid_trd[cmd_q.act])                      chk_status = RSP_INV;
    else if (cmd_q.op != CMD_INIT && !valid_trd[cmd_q.obj]) chk_status = RSP_INV;
  end

  // Pulses are the registered ISSUE state gated live by stall and flush.
  assign fire     = (state_q == S_ISSUE) && !stall && !flush && (chk_status == RSP_OK);
  assign init_trd = fire && (cmd_q.op == CMD_INIT);
  assign kill     = fire && (cmd_q.op == CMD_KILL);
  assign slp      = fire && (cmd_q.op == CMD_SLP);
  assign wake     = fire && (cmd_q.op == CMD_WAKE);

  assign act_trd  = (state_q != S_IDLE) ? cmd_q.act : '0;
  assign obj_trd  = (state_q != S_IDLE) ? cmd_q.obj : '0;
  assign init_pc  = (state_q != S_IDLE) ? cmd_q.pc  : '0;

  assign bus.req_ready  = !full;
  assign bus.rsp_valid  = (state_q == S_RESP) && !flush;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_trd    = rsp_trd_q;
  assign busy           = (state_q != S_IDLE) || (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      rsp_status_q <= RSP_OK;
      rsp_trd_q    <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            cmd_q   <= head;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!stall) begin
            if (chk_status == RSP_OK) begin
              state_q <= S_WAIT;
            end else begin
              rsp_status_q <= chk_status;
              rsp_trd_q    <= (cmd_q.op == CMD_INIT) ? cmd_q.act : cmd_q.obj;
              state_q      <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (trd_of)          rsp_status_q <= RSP_OF;
          else if (invalid_op) rsp_status_q <= RSP_INV;
          else                 rsp_status_q <= RSP_OK;
          // A failed INIT has no new thread, so it reports the issuing thread.
          if (cmd_q.op != CMD_INIT)       rsp_trd_q <= cmd_q.obj;
          else if (trd_of || invalid_op)  rsp_trd_q <= cmd_q.act;
          else                            rsp_trd_q <= new_trd;
          state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trd_cmd_seq.sv
// Directed bench for trd_cmd_seq: stimulus pushes expected pulses/responses
// into queues, a negedge monitor pops and compares them as the DUT emits them.
module tb_trd_cmd_seq;
  import trd_cmd_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, stall, trd_full, trd_of, invalid_op;
  logic [7:0]  valid_trd;
  logic [2:0]  new_trd;
  logic        init_trd, kill, slp, wake, busy;
  logic [2:0]  act_trd, obj_trd;
  logic [31:0] init_pc;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    int          kind;
    logic [2:0]  act;
    logic [2:0]  obj;
    logic [31:0] pc;
    int          cyc;
  } pexp_t;

  typedef struct {
    trd_rsp_e   st;
    logic [2:0] trd;
    int         cyc;
  } rexp_t;

  pexp_t pq[$];
  rexp_t rq[$];

  trd_cmd_seq_if bus ();

  trd_cmd_seq #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .stall      (stall),
    .valid_trd  (valid_trd),
    .trd_full   (trd_full),
    .trd_of     (trd_of),
    .invalid_op (invalid_op),
    .new_trd    (new_trd),
    .init_trd   (init_trd),
    .kill       (kill),
    .slp        (slp),
    .wake       (wake),
    .act_trd    (act_trd),
    .obj_trd    (obj_trd),
    .init_pc    (init_pc),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one request for one cycle; called at posedge+1.
  task automatic send(input logic [2:0] op, input logic [2:0] act, input logic [2:0] obj,
                      input logic [31:0] pc, input bit exp_rdy,
                      input bit exp_pulse, input int p_off,
                      input bit exp_rsp, input trd_rsp_e st, input logic [2:0] trd,
                      input int r_off);
    pexp_t p;
    rexp_t r;
    bus.req_valid   = 1'b1;
    bus.req_op      = op;
    bus.req_act_trd = act;
    bus.req_obj_trd = obj;
    bus.req_pc      = pc;
    chk("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_rdy});
    if (exp_rdy && exp_pulse) begin
      p.kind = int'(op); p.act = act; p.obj = obj; p.pc = pc; p.cyc = cyc + p_off;
      pq.push_back(p);
    end
    if (exp_rdy && exp_rsp) begin
      r.st = st; r.trd = trd; r.cyc = cyc + r_off;
      rq.push_back(r);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
  endtask

  task automatic drain();
    int k = 0;
    while ((pq.size() != 0 || rq.size() != 0 || busy) && k < 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_in_time", {31'd0, (k < 60)}, 32'd1);
    idle(2);
  endtask

  // Monitor: every pulse and every response must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      int    n;
      int    kind;
      pexp_t p;
      rexp_t r;
      n = int'(init_trd) + int'(kill) + int'(slp) + int'(wake);
      if (n != 0) begin
        chk("one_hot_pulse", n, 1);
        kind = init_trd ? 1 : kill ? 2 : slp ? 3 : 4;
        if (pq.size() == 0) begin
          chk("unexpected_pulse", kind, 0);
        end else begin
          p = pq.pop_front();
          chk("pulse_kind", kind, p.kind);
          chk("pulse_cycle", cyc, p.cyc);
          chk("pulse_act", {29'd0, act_trd}, {29'd0, p.act});
          chk("pulse_obj", {29'd0, obj_trd}, {29'd0, p.obj});
          chk("pulse_pc", init_pc, p.pc);
        end
      end
      if (bus.rsp_valid) begin
        if (rq.size() == 0) begin
          chk("unexpected_rsp", {29'd0, bus.rsp_trd}, 32'hdead);
        end else begin
          r = rq.pop_front();
          chk("rsp_status", {30'd0, bus.rsp_status}, {30'd0, r.st});
          chk("rsp_trd", {29'd0, bus.rsp_trd}, {29'd0, r.trd});
          chk("rsp_cycle", cyc, r.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; stall = 1'b0; trd_full = 1'b0; trd_of = 1'b0; invalid_op = 1'b0;
    valid_trd = 8'h00; new_trd = 3'd0;
    bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_act_trd = 3'd0;
    bus.req_obj_trd = 3'd0; bus.req_pc = 32'd0;
    idle(3);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulses", {28'd0, init_trd, kill, slp, wake}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_status", {30'd0, bus.rsp_status}, 32'd0);
    chk("rst_rsp_trd", {29'd0, bus.rsp_trd}, 32'd0);
    chk("rst_operands", {26'd0, act_trd, obj_trd}, 32'd0);
    chk("rst_init_pc", init_pc, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // INIT act=0 pc=0x100, thread_ctrl hands out thread 1
    valid_trd = 8'h01; new_trd = 3'd1;
    send(3'd1, 3'd0, 3'd0, 32'h100, 1, 1, 2, 1, RSP_OK, 3'd1, 4);
    drain();

    // NOP and an illegal op are dropped: no pulse, no response, not busy
    send(3'd0, 3'd1, 3'd1, 32'h0, 1, 0, 0, 0, RSP_OK, 3'd0, 0);
    send(3'd6, 3'd1, 3'd1, 32'h0, 1, 0, 0, 0, RSP_OK, 3'd0, 0);
    chk("drop_busy", {31'd0, busy}, 32'd0);
    idle(4);

    // SLP held in ISSUE by stall for 3 cycles
    valid_trd = 8'h03; stall = 1'b1;
    send(3'd3, 3'd0, 3'd1, 32'h0, 1, 1, 5, 1, RSP_OK, 3'd1, 7);
    idle(4);
    stall = 1'b0;
    drain();

    // Pre-check rejects: INIT with trd_full -> OF, KILL of dead thread -> INV
    trd_full = 1'b1;
    send(3'd1, 3'd0, 3'd0, 32'h40, 1, 0, 0, 1, RSP_OF, 3'd0, 3);
    drain();
    trd_full = 1'b0;
    send(3'd2, 3'd0, 3'd5, 32'h0, 1, 0, 0, 1, RSP_INV, 3'd5, 3);
    drain();

    // KILL issued but thread_ctrl flags invalid_op in WAIT
    valid_trd = 8'h05; invalid_op = 1'b1;
    send(3'd2, 3'd2, 3'd0, 32'h0, 1, 1, 2, 1, RSP_INV, 3'd0, 4);
    drain();
    invalid_op = 1'b0;

    // Backlog: one command parked in stalled ISSUE, then 5 back-to-back pushes
    valid_trd = 8'hFF; new_trd = 3'd6; stall = 1'b1;
    send(3'd4, 3'd0, 3'd1, 32'h0, 1, 1, 7, 1, RSP_OK, 3'd1, 9);
    idle(1);
    send(3'd3, 3'd3, 3'd4, 32'h0,   1, 1,  9, 1, RSP_OK, 3'd4, 11);
    send(3'd2, 3'd0, 3'd7, 32'h0,   1, 1, 12, 1, RSP_OK, 3'd7, 14);
    send(3'd1, 3'd5, 3'd0, 32'h200, 1, 1, 15, 1, RSP_OK, 3'd6, 17);
    send(3'd4, 3'd2, 3'd2, 32'h0,   1, 1, 18, 1, RSP_OK, 3'd2, 20);
    send(3'd4, 3'd1, 3'd1, 32'h0,   0, 0,  0, 0, RSP_OK, 3'd0, 0);
    stall = 1'b0;
    drain();

    // Flush while the first command sits in WAIT with two more queued
    send(3'd2, 3'd1, 3'd2, 32'h0, 1, 1, 2, 0, RSP_OK, 3'd0, 0);
    send(3'd4, 3'd1, 3'd3, 32'h0, 1, 0, 0, 0, RSP_OK, 3'd0, 0);
    send(3'd3, 3'd1, 3'd4, 32'h0, 1, 0, 0, 0, RSP_OK, 3'd0, 0);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_ready", {31'd0, bus.req_ready}, 32'd1);
    idle(8);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
